// File: rtl/noc_pkg.sv
// Shared mesh definitions: coordinate and payload widths plus the packet
// format carried on every mesh link.
package noc_pkg;

  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = 32;

  typedef struct packed {
    logic [COORD_W-1:0]   dst_x;
    logic [COORD_W-1:0]   dst_y;
    logic [COORD_W-1:0]   src_x;
    logic [COORD_W-1:0]   src_y;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;

endpackage

// File: rtl/node_port.sv
// One directional mesh link: packet data with valid/ready handshake.
//   up   : the sender side (drives data/valid, samples ready)
//   down : the receiver side (samples data/valid, drives ready)
interface node_port;
  import noc_pkg::*;

  packet_t data;
  logic    valid;
  logic    ready;

  modport up   (output data, output valid, input  ready);
  modport down (input  data, input  valid, output ready);
endinterface

// File: rtl/noc_fifo.sv
// Generic packet FIFO with registered occupancy.
//   push/push_data : write request, ignored while full
//   pop/pop_data   : read request, ignored while empty; pop_data is the head
//   full/empty     : derived only from the registered pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
module noc_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  packet_t push_data,
  input  logic    pop,
  output packet_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  packet_t     mem_q [DEPTH];
  logic        do_push, do_pop;

  always_comb begin
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    empty   = (wptr_q == rptr_q);
    // A full FIFO refuses the push even if the head leaves this cycle.
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + (AW+1)'(do_push);
    rptr_d  = rptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: contents are only observed when non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

  assign pop_data = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/mesh_endpoint.sv
// Edge network interface between a local client and one mesh boundary port.
//   to_mesh    : packets injected into the mesh (head of the TX FIFO)
//   from_mesh  : packets arriving from the mesh
//   tx_*       : client request channel (destination + payload)
//   rx_*       : client delivery channel (source + payload)
//   drop_count : saturating count of arrivals not addressed to (X,Y)
module mesh_endpoint
  import noc_pkg::*;
#(
  parameter int X        = 0,
  parameter int Y        = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  node_port.up                 to_mesh,
  node_port.down               from_mesh,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [COORD_W-1:0]   tx_dst_x,
  input  logic [COORD_W-1:0]   tx_dst_y,
  input  logic [PAYLOAD_W-1:0] tx_payload,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [COORD_W-1:0]   rx_src_x,
  output logic [COORD_W-1:0]   rx_src_y,
  output logic [PAYLOAD_W-1:0] rx_payload,
  output logic [15:0]          drop_count
);

  localparam logic [COORD_W-1:0] OWN_X = COORD_W'(X);
  localparam logic [COORD_W-1:0] OWN_Y = COORD_W'(Y);

  // ---------------- transmit ----------------
  packet_t tx_pkt, tx_head;
  logic    tx_full, tx_empty, tx_push, tx_pop;

  always_comb begin
    tx_pkt = '{dst_x: tx_dst_x, dst_y: tx_dst_y,
               src_x: OWN_X,    src_y: OWN_Y,
               payload: tx_payload};
    tx_push = tx_valid && !tx_full;
    tx_pop  = !tx_empty && to_mesh.ready;
  end

  assign tx_ready      = !tx_full;
  assign to_mesh.valid = !tx_empty;
  assign to_mesh.data  = tx_head;

  noc_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (tx_pkt),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // ---------------- receive ----------------
  packet_t     rx_head;
  logic        rx_full, rx_empty, rx_acc, rx_hit, rx_push, rx_pop;
  logic [15:0] drop_count_q, drop_count_d;
  logic        unused_rx_dst;

  always_comb begin
    rx_acc  = from_mesh.valid && !rx_full;
    rx_hit  = (from_mesh.data.dst_x == OWN_X) && (from_mesh.data.dst_y == OWN_Y);
    // Misrouted packets are still acknowledged so they leave the mesh.
    rx_push = rx_acc && rx_hit;
    rx_pop  = !rx_empty && rx_ready;
    drop_count_d = drop_count_q;
    if (rx_acc && !rx_hit && drop_count_q != 16'hFFFF)
      drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_count_q <= '0;
    else     drop_count_q <= drop_count_d;
  end

  assign from_mesh.ready = !rx_full;
  assign rx_valid        = !rx_empty;
  assign rx_src_x        = rx_head.src_x;
  assign rx_src_y        = rx_head.src_y;
  assign rx_payload      = rx_head.payload;
  assign drop_count      = drop_count_q;
  // Destination of a delivered packet is always our own; not forwarded.
  assign unused_rx_dst   = ^{rx_head.dst_x, rx_head.dst_y};

  noc_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (from_mesh.data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

endmodule
